// File: rtl/marker_pkg.sv
// Shared definitions for the user-marker generator and its rate controller:
// rate encodings, rate validation and the rate-change sequencer state type.
package marker_pkg;

  localparam int unsigned RATE_W = 4;
  localparam int unsigned CNT_W  = 8;

  localparam logic [RATE_W-1:0] RATE_FULL    = 4'h1;
  localparam logic [RATE_W-1:0] RATE_HALF    = 4'h2;
  localparam logic [RATE_W-1:0] RATE_QUARTER = 4'h4;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_DRAIN,
    ST_HOLD,
    ST_SETTLE
  } rate_state_e;

  function automatic logic rate_valid(input logic [RATE_W-1:0] rate);
    return (rate == RATE_FULL) || (rate == RATE_HALF) || (rate == RATE_QUARTER);
  endfunction

endpackage

// File: rtl/marker_rate_ctrl.sv
// Rate reconfiguration sequencer for the marker generator: drain the datapath,
// apply new rates under generator reset, settle, then re-enable and acknowledge.
module marker_rate_ctrl
  import marker_pkg::*;
#(
  parameter int unsigned DRAIN_CYCLES  = 8,
  parameter int unsigned SETTLE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_req,
  input  logic [RATE_W-1:0] cfg_local_rate,
  input  logic [RATE_W-1:0] cfg_remote_rate,
  output logic              cfg_ack,
  output logic              cfg_err,
  output logic [RATE_W-1:0] local_rate,
  output logic [RATE_W-1:0] remote_rate,
  output logic              gen_rst_n,
  output logic              tx_enable,
  output logic              busy
);

  localparam logic [CNT_W-1:0] DRAIN_LAST  = CNT_W'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LAST   = CNT_W'(1);
  localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  rate_state_e       r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic [RATE_W-1:0] r_cap_local;
  logic [RATE_W-1:0] r_cap_remote;
  logic [RATE_W-1:0] r_local;
  logic [RATE_W-1:0] r_remote;
  logic              r_gen_rst_n;
  logic              r_tx_enable;
  logic              r_busy;
  logic              r_cfg_ack;
  logic              r_cfg_err;
  logic              r_post_reset;

  rate_state_e       w_nxt_state;
  logic [CNT_W-1:0]  w_nxt_cnt;
  logic [RATE_W-1:0] w_nxt_cap_local;
  logic [RATE_W-1:0] w_nxt_cap_remote;
  logic [RATE_W-1:0] w_nxt_local;
  logic [RATE_W-1:0] w_nxt_remote;
  logic              w_nxt_ack;
  logic              w_nxt_err;
  logic              w_nxt_post_reset;

  // Next-state, counter and rate/ack decisions.
  always_comb begin
    w_nxt_state      = r_state;
    w_nxt_cnt        = r_cnt;
    w_nxt_cap_local  = r_cap_local;
    w_nxt_cap_remote = r_cap_remote;
    w_nxt_local      = r_local;
    w_nxt_remote     = r_remote;
    w_nxt_ack        = 1'b0;
    w_nxt_err        = 1'b0;
    w_nxt_post_reset = r_post_reset;

    unique case (r_state)
      ST_IDLE: begin
        // A request still high during its own ack cycle is not re-accepted.
        if (cfg_req && !r_cfg_ack) begin
          if (!rate_valid(cfg_local_rate) || !rate_valid(cfg_remote_rate)) begin
            w_nxt_ack = 1'b1;
            w_nxt_err = 1'b1;
          end else if ((cfg_local_rate == r_local) && (cfg_remote_rate == r_remote)) begin
            w_nxt_ack = 1'b1;
          end else begin
            w_nxt_cap_local  = cfg_local_rate;
            w_nxt_cap_remote = cfg_remote_rate;
            w_nxt_state      = ST_DRAIN;
            w_nxt_cnt        = '0;
          end
        end
      end
      ST_DRAIN: begin
        if (r_cnt == DRAIN_LAST) begin
          w_nxt_state  = ST_HOLD;
          w_nxt_cnt    = '0;
          w_nxt_local  = r_cap_local;
          w_nxt_remote = r_cap_remote;
        end else begin
          w_nxt_cnt = r_cnt + CNT_W'(1);
        end
      end
      ST_HOLD: begin
        if (r_cnt == HOLD_LAST) begin
          w_nxt_state = ST_SETTLE;
          w_nxt_cnt   = '0;
        end else begin
          w_nxt_cnt = r_cnt + CNT_W'(1);
        end
      end
      ST_SETTLE: begin
        if (r_cnt == SETTLE_LAST) begin
          w_nxt_state      = ST_IDLE;
          w_nxt_cnt        = '0;
          w_nxt_ack        = !r_post_reset;
          w_nxt_post_reset = 1'b0;
        end else begin
          w_nxt_cnt = r_cnt + CNT_W'(1);
        end
      end
      default: begin
        w_nxt_state = ST_HOLD;
        w_nxt_cnt   = '0;
      end
    endcase
  end

  // State and registered outputs; outputs are decoded from the next state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= ST_HOLD;
      r_cnt        <= '0;
      r_cap_local  <= RATE_FULL;
      r_cap_remote <= RATE_FULL;
      r_local      <= RATE_FULL;
      r_remote     <= RATE_FULL;
      r_gen_rst_n  <= 1'b0;
      r_tx_enable  <= 1'b0;
      r_busy       <= 1'b1;
      r_cfg_ack    <= 1'b0;
      r_cfg_err    <= 1'b0;
      r_post_reset <= 1'b1;
    end else begin
      r_state      <= w_nxt_state;
      r_cnt        <= w_nxt_cnt;
      r_cap_local  <= w_nxt_cap_local;
      r_cap_remote <= w_nxt_cap_remote;
      r_local      <= w_nxt_local;
      r_remote     <= w_nxt_remote;
      r_gen_rst_n  <= (w_nxt_state != ST_HOLD);
      r_tx_enable  <= (w_nxt_state == ST_IDLE);
      r_busy       <= (w_nxt_state != ST_IDLE);
      r_cfg_ack    <= w_nxt_ack;
      r_cfg_err    <= w_nxt_err;
      r_post_reset <= w_nxt_post_reset;
    end
  end

  assign cfg_ack     = r_cfg_ack;
  assign cfg_err     = r_cfg_err;
  assign local_rate  = r_local;
  assign remote_rate = r_remote;
  assign gen_rst_n   = r_gen_rst_n;
  assign tx_enable   = r_tx_enable;
  assign busy        = r_busy;

endmodule

// File: tb/tb_marker_rate_ctrl.sv
// Bench for marker_rate_ctrl: directed scenarios plus random requests, every
// cycle compared against a timeline model of the rate-change sequence.
module tb_marker_rate_ctrl;

  localparam int D = 8;
  localparam int S = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cfg_req;
  logic [3:0] cfg_local_rate;
  logic [3:0] cfg_remote_rate;
  logic       cfg_ack;
  logic       cfg_err;
  logic [3:0] local_rate;
  logic [3:0] remote_rate;
  logic       gen_rst_n;
  logic       tx_enable;
  logic       busy;

  always #5 clk = ~clk;

  marker_rate_ctrl #(.DRAIN_CYCLES(D), .SETTLE_CYCLES(S)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .cfg_req         (cfg_req),
    .cfg_local_rate  (cfg_local_rate),
    .cfg_remote_rate (cfg_remote_rate),
    .cfg_ack         (cfg_ack),
    .cfg_err         (cfg_err),
    .local_rate      (local_rate),
    .remote_rate     (remote_rate),
    .gen_rst_n       (gen_rst_n),
    .tx_enable       (tx_enable),
    .busy            (busy)
  );

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  int          cyc      = 0;

  // Model: a sequence is a timeline indexed by k = cycles since the accept edge.
  logic [3:0] m_loc, m_rem, m_pend_loc, m_pend_rem;
  bit         m_in_seq, m_post, m_ack, m_err;
  int         m_k;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s cycle %0d: got %0h expected %0h", tag, cyc, act, exp);
  endtask

  function automatic bit is_rate(input logic [3:0] r);
    return (r == 4'h1) || (r == 4'h2) || (r == 4'h4);
  endfunction

  function automatic logic [3:0] pick_rate();
    int unsigned r;
    logic [3:0]  v;
    r = $urandom_range(0, 9);
    if (r < 3) v = 4'h1;
    else if (r < 6) v = 4'h2;
    else if (r < 9) v = 4'h4;
    else v = 4'($urandom_range(0, 15));
    return v;
  endfunction

  // Reset looks like a sequence sitting at its first generator-reset cycle.
  task automatic model_reset();
    m_loc    = 4'h1;
    m_rem    = 4'h1;
    m_in_seq = 1'b1;
    m_k      = D + 1;
    m_post   = 1'b1;
    m_ack    = 1'b0;
    m_err    = 1'b0;
  endtask

  task automatic model_edge();
    bit prev_ack;
    prev_ack = m_ack;
    m_ack = 1'b0;
    m_err = 1'b0;
    if (m_in_seq) begin
      m_k++;
      if (m_k == D + 1) begin
        m_loc = m_pend_loc;
        m_rem = m_pend_rem;
      end
      if (m_k == D + 3 + S) begin
        m_in_seq = 1'b0;
        m_ack    = !m_post;
        m_post   = 1'b0;
      end
    end else if (cfg_req && !prev_ack) begin
      if (!is_rate(cfg_local_rate) || !is_rate(cfg_remote_rate)) begin
        m_ack = 1'b1;
        m_err = 1'b1;
      end else if (cfg_local_rate == m_loc && cfg_remote_rate == m_rem) begin
        m_ack = 1'b1;
      end else begin
        m_pend_loc = cfg_local_rate;
        m_pend_rem = cfg_remote_rate;
        m_in_seq   = 1'b1;
        m_k        = 1;
      end
    end
  endtask

  task automatic compare_all();
    check("tx_enable", 32'(tx_enable), 32'(!m_in_seq));
    check("busy", 32'(busy), 32'(m_in_seq));
    check("gen_rst_n", 32'(gen_rst_n), 32'(!(m_in_seq && (m_k == D + 1 || m_k == D + 2))));
    check("local_rate", 32'(local_rate), 32'(m_loc));
    check("remote_rate", 32'(remote_rate), 32'(m_rem));
    check("cfg_ack", 32'(cfg_ack), 32'(m_ack));
    if (m_ack) check("cfg_err", 32'(cfg_err), 32'(m_err));
  endtask

  task automatic step();
    @(posedge clk);
    cyc++;
    if (rst_n) model_edge();
    #1;
    compare_all();
  endtask

  // Hold the request until acknowledged; latency counted from the sampling edge.
  task automatic wait_ack(output int lat);
    int start;
    int n;
    start = cyc + 1;
    n = 0;
    do begin
      step();
      n++;
    end while (!cfg_ack && n < 100);
    if (!cfg_ack) check("ack_timeout", 32'd0, 32'd1);
    lat = cyc + 1 - start;
    cfg_req = 1'b0;
  endtask

  task automatic count_to_enable(input string tag);
    int n;
    n = 0;
    while (!tx_enable && n < 50) begin
      step();
      n++;
    end
    check(tag, 32'(n), 32'(2 + S));
  endtask

  initial begin
    int lat;
    int n;
    cfg_req         = 1'b0;
    cfg_local_rate  = 4'h1;
    cfg_remote_rate = 4'h1;
    rst_n           = 1'b0;
    model_reset();
    #12;
    compare_all();
    rst_n = 1'b1;
    count_to_enable("post_reset_enable_cycle");
    repeat (4) step();

    // Full change, with inputs disturbed during DRAIN.
    cfg_local_rate  = 4'h2;
    cfg_remote_rate = 4'h4;
    cfg_req         = 1'b1;
    step();
    cfg_local_rate  = 4'h4;
    cfg_remote_rate = 4'h4;
    wait_ack(lat);
    check("change_latency", 32'(lat + 1), 32'(D + 3 + S));
    check("applied_local", 32'(local_rate), 32'h2);
    check("applied_remote", 32'(remote_rate), 32'h4);
    step();

    // Invalid rate rejected.
    cfg_local_rate  = 4'h3;
    cfg_remote_rate = 4'h1;
    cfg_req         = 1'b1;
    wait_ack(lat);
    check("reject_latency", 32'(lat), 32'd1);
    check("reject_err", 32'(cfg_err), 32'd1);
    check("reject_tx", 32'(tx_enable), 32'd1);
    step();

    // No-op request equal to current rates.
    cfg_local_rate  = 4'h2;
    cfg_remote_rate = 4'h4;
    cfg_req         = 1'b1;
    wait_ack(lat);
    check("noop_latency", 32'(lat), 32'd1);
    check("noop_err", 32'(cfg_err), 32'd0);
    step();

    // Reset during SETTLE drops the request.
    cfg_local_rate  = 4'h1;
    cfg_remote_rate = 4'h2;
    cfg_req         = 1'b1;
    step();
    cfg_req = 1'b0;
    n = 0;
    while (!(m_in_seq && m_k == D + 4) && n < 50) begin
      step();
      n++;
    end
    check("in_settle", 32'({gen_rst_n, tx_enable}), 32'b10);
    #2;
    rst_n = 1'b0;
    model_reset();
    #1;
    compare_all();
    step();
    step();
    rst_n = 1'b1;
    count_to_enable("rereset_enable_cycle");
    check("rereset_local", 32'(local_rate), 32'h1);
    check("rereset_remote", 32'(remote_rate), 32'h1);

    // Random request traffic.
    for (int i = 0; i < 2000; i++) begin
      if (cfg_req && m_ack) cfg_req = ($urandom_range(0, 3) == 0);
      else if (!cfg_req && $urandom_range(0, 7) == 0) begin
        cfg_req         = 1'b1;
        cfg_local_rate  = pick_rate();
        cfg_remote_rate = pick_rate();
      end
      if (m_in_seq) begin
        cfg_local_rate  = pick_rate();
        cfg_remote_rate = pick_rate();
      end
      step();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
